xmem_rd_arbiter: RTL and testbench

- Round-robin arbiter that shares the single XMEM read port between up to NUM_CLIENTS read clients, for example several copy/compute engines in the xbox accelerator.
- Each client uses the normal read handshake: hold req with addr/size until data returns.
- The arbiter locks a grant for one whole transaction, forwards the winner's request to memory, and routes mem_valid back only to the winner.
- Per-client grant counters are exported for host status registers.

---
 rtl/xmem_rd_arbiter.sv | 120 ++++++++++++
 tb/tb_xmem_rd_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xmem_rd_arbiter.sv
// rtl/xmem_rd_arbiter.sv - round-robin arbiter sharing the XMEM read port between read clients
// Holds one grant per whole transaction and steers mem_valid back to the winner only.
package xbox_def_pkg;
  parameter int XMEM_ADDR_WIDTH    = 24;
  parameter int BYTES_PER_MEM_LINE = 32;
endpackage

module xmem_rd_arbiter
  import xbox_def_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CLIENTS-1:0]                 cl_req,
  input  logic [NUM_CLIENTS*XMEM_ADDR_WIDTH-1:0] cl_addr,
  input  logic [NUM_CLIENTS*6-1:0]               cl_size,
  output logic [NUM_CLIENTS-1:0]                 cl_valid,
  output logic [BYTES_PER_MEM_LINE*8-1:0]        cl_data,
  output logic                                   mem_req,
  output logic [XMEM_ADDR_WIDTH-1:0]             mem_start_addr,
  output logic [5:0]                             mem_size_bytes,
  input  logic                                   mem_valid,
  input  logic [BYTES_PER_MEM_LINE*8-1:0]        mem_data,
  output logic                                   busy,
  output logic [$clog2(NUM_CLIENTS)-1:0]         gnt_id,
  output logic [NUM_CLIENTS*CNT_W-1:0]           gnt_cnt
);
  localparam int IDW = $clog2(NUM_CLIENTS);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [IDW-1:0]             gnt_q, gnt_d, last_q, last_d;
  logic [IDW-1:0]             pick_id, idx;
  logic                       pick_valid, done;
  logic [CNT_W-1:0]           cnt_q [NUM_CLIENTS];
  logic [XMEM_ADDR_WIDTH-1:0] addr_arr [NUM_CLIENTS];
  logic [5:0]                 size_arr [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign addr_arr[g]                 = cl_addr[g*XMEM_ADDR_WIDTH +: XMEM_ADDR_WIDTH];
    assign size_arr[g]                 = cl_size[g*6 +: 6];
    assign gnt_cnt[g*CNT_W +: CNT_W]   = cnt_q[g];
  end

  // Scan from farthest to nearest so the first requester after last wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      idx = IDW'((int'(last_q) + k) % NUM_CLIENTS);
      if (cl_req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          gnt_d   = pick_id;
        end
      end
      BUSY: begin
        if (mem_valid) begin
          state_d = IDLE;
          last_d  = gnt_q;
          done    = 1'b1;
        end else if (!cl_req[gnt_q]) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDW'(NUM_CLIENTS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLIENTS; i++) cnt_q[i] <= '0;
    end else if (done && (cnt_q[gnt_q] != '1)) begin
      cnt_q[gnt_q] <= cnt_q[gnt_q] + CNT_W'(1);
    end
  end

  assign busy           = (state_q == BUSY);
  assign gnt_id         = gnt_q;
  assign cl_data        = mem_data;
  assign mem_start_addr = addr_arr[gnt_q];
  assign mem_size_bytes = size_arr[gnt_q];
  // Drop the request in the data cycle, as a client would.
  assign mem_req        = busy & cl_req[gnt_q] & ~mem_valid;

  always_comb begin
    cl_valid = '0;
    if (busy && mem_valid) cl_valid[gnt_q] = 1'b1;
  end
endmodule

// File: tb/tb_xmem_rd_arbiter.sv
// tb/tb_xmem_rd_arbiter.sv - self-checking bench for xmem_rd_arbiter
// Directed scenarios plus randomized traffic scored against a transaction-level model.
module tb_xmem_rd_arbiter;
  import xbox_def_pkg::*;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int AW = XMEM_ADDR_WIDTH;
  localparam int DW = BYTES_PER_MEM_LINE * 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    cl_req;
  logic [N*AW-1:0] cl_addr;
  logic [N*6-1:0]  cl_size;
  logic [N-1:0]    cl_valid;
  logic [DW-1:0]   cl_data;
  logic            mem_req;
  logic [AW-1:0]   mem_start_addr;
  logic [5:0]      mem_size_bytes;
  logic            mem_valid;
  logic [DW-1:0]   mem_data;
  logic            busy;
  logic [1:0]      gnt_id;
  logic [N*CW-1:0] gnt_cnt;

  logic [1:0]      s_req;
  logic [2*AW-1:0] s_addr;
  logic [11:0]     s_size;
  logic [1:0]      s_cl_valid;
  logic [DW-1:0]   s_cl_data;
  logic            s_mem_req;
  logic [AW-1:0]   s_mem_addr;
  logic [5:0]      s_mem_size;
  logic            s_mem_valid;
  logic [DW-1:0]   s_mem_data;
  logic            s_busy;
  logic [0:0]      s_gnt_id;
  logic [5:0]      s_gnt_cnt;

  xmem_rd_arbiter #(.NUM_CLIENTS(N), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .cl_req(cl_req), .cl_addr(cl_addr), .cl_size(cl_size),
    .cl_valid(cl_valid), .cl_data(cl_data), .mem_req(mem_req), .mem_start_addr(mem_start_addr),
    .mem_size_bytes(mem_size_bytes), .mem_valid(mem_valid), .mem_data(mem_data),
    .busy(busy), .gnt_id(gnt_id), .gnt_cnt(gnt_cnt)
  );

  xmem_rd_arbiter #(.NUM_CLIENTS(2), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .cl_req(s_req), .cl_addr(s_addr), .cl_size(s_size),
    .cl_valid(s_cl_valid), .cl_data(s_cl_data), .mem_req(s_mem_req), .mem_start_addr(s_mem_addr),
    .mem_size_bytes(s_mem_size), .mem_valid(s_mem_valid), .mem_data(s_mem_data),
    .busy(s_busy), .gnt_id(s_gnt_id), .gnt_cnt(s_gnt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transaction-level reference state
  bit   m_busy;
  int   m_owner, m_last;
  int   m_cnt [N];
  int   rem [N];
  int   skip [N];
  int   done_q [$];
  int   gaps [$];
  int   mem_wait, mem_lat, cyc, t_valid;
  bit   obs_mem_req;
  logic [N-1:0] last_valid;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_client(input int c, input logic [AW-1:0] a, input logic [5:0] s, input int r);
    cl_addr[c*AW +: AW] = a;
    cl_size[c*6 +: 6]   = s;
    cl_req[c]           = 1'b1;
    rem[c]              = r;
  endtask

  // Apply the arbitration rules to the inputs sampled at a clock edge.
  task automatic model_edge(output int d);
    int p;
    d = -1;
    if (!m_busy) begin
      p = -1;
      for (int k = 1; k <= N; k++) begin
        if (cl_req[(m_last + k) % N]) begin
          p = (m_last + k) % N;
          break;
        end
      end
      for (int c = 0; c < N; c++) if (!cl_req[c]) skip[c] = 0;
      if (p >= 0) begin
        chk("starvation", skip[p] <= N - 1, 1'b1);
        for (int c = 0; c < N; c++) if (cl_req[c] && c != p) skip[c]++;
        skip[p] = 0;
        m_busy  = 1'b1;
        m_owner = p;
      end
    end else if (mem_valid) begin
      m_busy = 1'b0;
      m_last = m_owner;
      if (m_cnt[m_owner] < (1 << CW) - 1) m_cnt[m_owner]++;
      done_q.push_back(m_owner);
      d = m_owner;
    end else if (!cl_req[m_owner]) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end
  endtask

  // One clock edge: update the model, then let clients and the memory react.
  task automatic tick();
    int d;
    @(posedge clk);
    model_edge(d);
    #1;
    if (d >= 0) begin
      rem[d]--;
      if (rem[d] <= 0) begin
        cl_req[d] = 1'b0;
        rem[d]    = 0;
      end
    end
    if (mem_valid) begin
      mem_valid = 1'b0;
      mem_wait  = 0;
    end else if (obs_mem_req) begin
      mem_wait++;
      if (mem_wait >= mem_lat) begin
        mem_valid = 1'b1;
        mem_wait  = 0;
      end
    end else begin
      mem_wait = 0;
    end
    mem_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_out();
    logic [N*CW-1:0] ecnt;
    logic [N-1:0]    ev;
    @(negedge clk);
    cyc++;
    ev = '0;
    if (m_busy && mem_valid) ev[m_owner] = 1'b1;
    for (int c = 0; c < N; c++) ecnt[c*CW +: CW] = CW'(m_cnt[c]);
    chk("busy", busy, m_busy);
    chk("gnt_id", gnt_id, m_owner);
    chk("mem_req", mem_req, m_busy && cl_req[m_owner] && !mem_valid);
    if (m_busy) begin
      chk("mem_addr", mem_start_addr, cl_addr[m_owner*AW +: AW]);
      chk("mem_size", mem_size_bytes, cl_size[m_owner*6 +: 6]);
    end
    chk("cl_valid", cl_valid, ev);
    chk("cl_data", cl_data, mem_data);
    chk("gnt_cnt", gnt_cnt, ecnt);
    if (cl_valid != '0) begin
      last_valid = cl_valid;
      t_valid    = cyc;
    end
    if (mem_req && !obs_mem_req && t_valid >= 0) begin
      gaps.push_back(cyc - t_valid);
      t_valid = -1;
    end
    obs_mem_req = mem_req;
  endtask

  task automatic run_until(input string tag, input int n, input int lim);
    int k = 0;
    while (done_q.size() < n && k < lim) begin
      tick();
      check_out();
      k++;
    end
    chk(tag, done_q.size() >= n, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    rst_n       = 1'b0;
    cl_req      = '0;
    mem_valid   = 1'b0;
    mem_wait    = 0;
    obs_mem_req = 1'b0;
    s_req       = '0;
    s_mem_valid = 1'b0;
    m_busy      = 1'b0;
    m_owner     = 0;
    m_last      = N - 1;
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0;
      rem[c]   = 0;
      skip[c]  = 0;
    end
    done_q.delete();
    gaps.delete();
    t_valid    = -1;
    last_valid = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_cl_valid", cl_valid, '0);
    chk("rst_gnt_id", gnt_id, '0);
    chk("rst_gnt_cnt", gnt_cnt, '0);
    chk("rst_sat_cnt", s_gnt_cnt, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cl_req = '0; cl_addr = '0; cl_size = '0; mem_valid = 1'b0; mem_data = '0;
    s_req = '0; s_addr = '0; s_size = '0; s_mem_valid = 1'b0; s_mem_data = '0;
    rst_n = 1'b0; mem_lat = 3; cyc = 0;
    do_reset();

    // Single request from client 2
    tick();
    set_client(2, 24'h100, 6'd32, 1);
    check_out();
    chk("t1_wait", mem_req, 1'b0);
    tick();
    check_out();
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_addr", mem_start_addr, 24'h100);
    chk("t1_size", mem_size_bytes, 6'd32);
    run_until("t1_timeout", 1, 20);
    chk("t1_owner", done_q[0], 2);
    chk("t1_cl_valid", last_valid, 4'b0100);
    chk("t1_cnt2", gnt_cnt[2*CW +: CW], 1);

    // All clients requesting twice
    do_reset();
    for (int c = 0; c < N; c++) set_client(c, AW'(24'h1000 + c * 24'h40), 6'(8 * (c + 1)), 2);
    run_until("t2_timeout", 8, 80);
    for (int i = 0; i < 8; i++) chk("t2_order", done_q[i], i % 4);
    chk("t2_ngaps", gaps.size(), 7);
    foreach (gaps[i]) chk("t2_gap", gaps[i], 2);
    chk("t2_cnt", gnt_cnt, {4{16'd2}});

    // Priority rotation after client 3 is served
    do_reset();
    set_client(3, 24'h300, 6'd16, 1);
    run_until("t3a_timeout", 1, 20);
    set_client(0, 24'h040, 6'd4, 1);
    set_client(3, 24'h380, 6'd8, 1);
    run_until("t3b_timeout", 3, 40);
    chk("t3_first", done_q[1], 0);
    chk("t3_second", done_q[2], 3);

    // No pre-emption of client 1 by client 0
    do_reset();
    set_client(1, 24'h2A0, 6'd12, 1);
    tick();
    check_out();
    set_client(0, 24'h010, 6'd20, 1);
    for (int k = 0; k < 20 && done_q.size() == 0; k++) begin
      tick();
      check_out();
      if (m_busy) chk("t4_addr_hold", mem_start_addr, 24'h2A0);
    end
    run_until("t4_timeout", 2, 20);
    chk("t4_first", done_q[0], 1);
    chk("t4_second", done_q[1], 0);

    // Abort by the granted client, then spurious valid while idle
    do_reset();
    set_client(2, 24'h500, 6'd32, 1);
    tick();
    check_out();
    chk("t5_busy", busy, 1'b1);
    tick();
    cl_req[2] = 1'b0;
    rem[2]    = 0;
    check_out();
    chk("t5_abort_req", mem_req, 1'b0);
    tick();
    check_out();
    chk("t5_idle", busy, 1'b0);
    chk("t5_cnt", gnt_cnt, '0);
    tick();
    mem_valid = 1'b1;
    check_out();
    chk("t5_spur_valid", cl_valid, '0);
    tick();
    check_out();
    chk("t5_spur_cnt", gnt_cnt, '0);
    chk("t5_spur_busy", busy, 1'b0);

    // Reset while a transaction is outstanding
    do_reset();
    set_client(1, 24'h600, 6'd8, 2);
    run_until("t6_timeout", 1, 20);
    tick();
    check_out();
    chk("t6_busy_before", busy, 1'b1);
    chk("t6_cnt_before", gnt_cnt[CW +: CW], 1);
    do_reset();
    tick();
    check_out();

    // Randomized traffic with aborts and spurious valids
    do_reset();
    for (int it = 0; it < 1500; it++) begin
      tick();
      if (mem_wait == 0 && !mem_valid) mem_lat = 1 + int'($urandom_range(0, 3));
      for (int c = 0; c < N; c++)
        if (!cl_req[c] && $urandom_range(0, 3) == 0)
          set_client(c, AW'($urandom), 6'($urandom_range(0, 32)), int'($urandom_range(1, 2)));
      if (m_busy && !mem_valid && cl_req[m_owner] && $urandom_range(0, 49) == 0) begin
        cl_req[m_owner] = 1'b0;
        rem[m_owner]    = 0;
      end
      if (!m_busy && !mem_valid && mem_wait == 0 && $urandom_range(0, 9) == 0) mem_valid = 1'b1;
      check_out();
    end

    // Counter saturation on a narrow instance
    do_reset();
    s_req = 2'b01;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      s_mem_valid = 1'b1;
      @(negedge clk);
      chk("sat_cl_valid", s_cl_valid, 2'b01);
      chk("sat_mem_req", s_mem_req, 1'b0);
      @(posedge clk);
      #1;
      s_mem_valid = 1'b0;
      chk("sat_cnt0", s_gnt_cnt[2:0], (k + 1 < 7) ? k + 1 : 7);
      chk("sat_cnt1", s_gnt_cnt[5:3], 0);
      chk("sat_idle", s_busy, 1'b0);
    end
    s_req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
